vector_result_writeback: RTL
============================

Name: vector_result_writeback

Overview:
- Sequential back-end for the integer vector add path. Collects the 64-bit per-chunk results (vd, vd_high) the add unit produces for one instruction and issues them as chunk writes to the vector register file write port.
- Handles three cases: normal results, widening results (two writes per chunk) and mask results (bit packing into a single mask word).
- Sits between the integer execution stage and the vector register file.

Parameters:
- CHUNKS_PER_REG, 8, 64-bit chunks per vector register (VLEN = 512); power of two.
- REG_INDEX_WIDTH, 5, vector register index width.
- CHUNK_INDEX_WIDTH, 3, log2(CHUNKS_PER_REG).

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  command strobe, sampled only in IDLE.
- vd_index  in  REG_INDEX_WIDTH  base destination register.
- chunk_count  in  4  result chunks to expect (0..8).
- bit_mode  in  2  SEW: 0=8, 1=16, 2=32, 3=64 bit.
- mask_mode  in  1  results are mask bits; overrides widening_mode.
- widening_mode  in  1  each result carries vd and vd_high.
- result_valid  in  1  result chunk present.
- result_ready  out  1  block accepts result chunk.
- result_vd  in  64  low/normal result chunk.
- result_vd_high  in  64  high result chunk (widening only).
- write_valid  out  1  register-file write request.
- write_ready  in  1  register file accepts write.
- write_index  out  REG_INDEX_WIDTH  destination register.
- write_chunk  out  CHUNK_INDEX_WIDTH  chunk within register.
- write_data  out  64  write payload.
- busy  out  1  instruction in progress (not IDLE).
- done  out  1  one-cycle pulse at instruction completion.

Behaviour:
- Reset values: result_ready=0, write_valid=0, write_index=0, write_chunk=0, write_data=0, busy=0, done=0. The mask accumulator, chunk counter and hold registers clear to 0. Reset asserted in any state returns to IDLE at once and discards pending writes.
- States: IDLE, COLLECT, WRITE_LOW, WRITE_HIGH, WRITE_MASK, DONE.
- IDLE: on start, latch vd_index, chunk_count, bit_mode, mask_mode and widening_mode, then go to COLLECT. A latched chunk_count of 0 goes to DONE instead. start in any other state is ignored.
- COLLECT:
  - result_ready=1 (combinational from state).
  - A handshake (valid & ready) at cycle c registers result_vd/result_vd_high and increments the chunk counter k.
  - Next state is WRITE_LOW for normal or widening results.
  - In mask mode, next state is COLLECT, or WRITE_MASK if k was the last chunk.
- Mask packing: bits per chunk n = 8/4/2/1 for bit_mode 0/1/2/3, taken from result_vd[n-1:0]. Chunk k's bits go to accumulator bits [k*n+n-1 : k*n]. Unfilled bits are 0.
- WRITE_LOW:
  - write_valid=1 with data=held vd.
  - Linear address L = vd_index*CHUNKS_PER_REG + (widening ? 2k : k). write_index = L / CHUNKS_PER_REG (mod 2^REG_INDEX_WIDTH); write_chunk = L mod CHUNKS_PER_REG.
  - On write_ready: go to WRITE_HIGH if widening; otherwise COLLECT, or DONE if last chunk.
- WRITE_HIGH: write held vd_high to linear address 2k+1 (same mapping). On write_ready: COLLECT, or DONE if last chunk.
- WRITE_MASK: write the accumulator to (vd_index, chunk 0). On write_ready: DONE.
- Write stability: write_valid, write_index, write_chunk and write_data are registered and stay stable while write_valid=1 and write_ready=0. result_ready=0 in every write state.
- DONE: done=1 for one cycle, then IDLE. busy=1 in all states except IDLE.
- Latency:
  - start at t → busy and result_ready at t+1.
  - Accept at c → write_valid at c+1.
  - Last write handshake at w → done at w+1, busy=0 at w+2.
  - Minimum throughput: 2 cycles per normal chunk, 3 per widening chunk.

Test Plan:
- Normal path: bit_mode=3, chunk_count=2, vd_index=3; results 0x1111_1111_1111_1111 then 0x2222_2222_2222_2222, write_ready=1 → writes (3,0,0x1111…) and (3,1,0x2222…), then one done pulse and busy=0.
- Widening across registers: chunk_count=5, vd_index=2; chunk k has vd=k, vd_high=0x100+k → ten writes to (2,0)…(2,7), then chunk 4 writes (3,0,0x4) and (3,1,0x104).
- Mask, 32-bit: bit_mode=2, chunk_count=3; result_vd low bits 2'b10, 2'b01, 2'b11 → single write (vd_index,0,0x0000_0000_0000_0036). Check that no write is issued before the last chunk.
- Mask, 8-bit full: chunk_count=8; low bytes 0x01…0x08 → write data 0x0807_0605_0403_0201. Check that mask_mode=1 with widening_mode=1 gives the same result.
- Backpressure and start: hold write_ready=0 for 5 cycles during WRITE_LOW → write_* stable and result_ready=0. Pulse start while busy → ignored. chunk_count=0 → done two cycles after start with no write.
- Reset mid-operation: assert reset during WRITE_HIGH → write_valid, busy and done drop asynchronously. After release, a new 1-chunk command completes normally.

Source files
------------

// File: rtl/vector_result_writeback.sv
// Vector add write-back: collects per-chunk results for one instruction and
// issues them as chunk writes (normal, widening pairs, or one packed mask word).
module vector_result_writeback #(
    parameter int CHUNKS_PER_REG    = 8,
    parameter int REG_INDEX_WIDTH   = 5,
    parameter int CHUNK_INDEX_WIDTH = 3
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic [REG_INDEX_WIDTH-1:0]   vd_index,
    input  logic [3:0]                   chunk_count,
    input  logic [1:0]                   bit_mode,
    input  logic                         mask_mode,
    input  logic                         widening_mode,
    input  logic                         result_valid,
    output logic                         result_ready,
    input  logic [63:0]                  result_vd,
    input  logic [63:0]                  result_vd_high,
    output logic                         write_valid,
    input  logic                         write_ready,
    output logic [REG_INDEX_WIDTH-1:0]   write_index,
    output logic [CHUNK_INDEX_WIDTH-1:0] write_chunk,
    output logic [63:0]                  write_data,
    output logic                         busy,
    output logic                         done
);
    localparam int LW = REG_INDEX_WIDTH + CHUNK_INDEX_WIDTH;

    typedef enum logic [2:0] {
        IDLE, COLLECT, WRITE_LOW, WRITE_HIGH, WRITE_MASK, DONE
    } state_t;

    state_t                       state_reg;
    logic [REG_INDEX_WIDTH-1:0]   vd_index_reg;
    logic [3:0]                   count_reg;
    logic [1:0]                   bit_mode_reg;
    logic                         mask_reg;
    logic                         widen_reg;
    logic [3:0]                   k_reg;
    logic [63:0]                  vd_high_hold_reg;
    logic [63:0]                  mask_acc_reg;
    logic                         write_valid_reg;
    logic [REG_INDEX_WIDTH-1:0]   write_index_reg;
    logic [CHUNK_INDEX_WIDTH-1:0] write_chunk_reg;
    logic [63:0]                  write_data_reg;
    logic                         done_reg;

    logic [4:0]    offset;
    logic [LW-1:0] lin_low;
    logic [LW-1:0] lin_high;
    logic [3:0]    field_n;
    logic [7:0]    field_bits;
    logic [6:0]    shift_amt;
    logic [63:0]   mask_next;
    logic          last_accept;
    logic          all_written;

    // Widening results occupy two chunk slots each, so chunk k lands at 2k.
    assign offset   = widen_reg ? {k_reg, 1'b0} : {1'b0, k_reg};
    assign lin_low  = LW'(vd_index_reg) * LW'(CHUNKS_PER_REG) + LW'(offset);
    assign lin_high = {write_index_reg, write_chunk_reg} + LW'(1);

    // One mask bit per element: 8/4/2/1 elements per chunk for SEW 8/16/32/64.
    assign field_n = 4'd8 >> bit_mode_reg;
    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_field
            assign field_bits[gi] = result_vd[gi] & (4'(gi) < field_n);
        end
    endgenerate
    assign shift_amt = 7'(k_reg) * 7'(field_n);
    assign mask_next = mask_acc_reg | (64'(field_bits) << shift_amt);

    assign last_accept = (k_reg + 4'd1) == count_reg;
    assign all_written = k_reg == count_reg;

    assign result_ready = (state_reg == COLLECT) && (count_reg != 4'd0);
    assign busy         = state_reg != IDLE;
    assign done         = done_reg;
    assign write_valid  = write_valid_reg;
    assign write_index  = write_index_reg;
    assign write_chunk  = write_chunk_reg;
    assign write_data   = write_data_reg;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg        <= IDLE;
            vd_index_reg     <= '0;
            count_reg        <= '0;
            bit_mode_reg     <= '0;
            mask_reg         <= 1'b0;
            widen_reg        <= 1'b0;
            k_reg            <= '0;
            vd_high_hold_reg <= '0;
            mask_acc_reg     <= '0;
            write_valid_reg  <= 1'b0;
            write_index_reg  <= '0;
            write_chunk_reg  <= '0;
            write_data_reg   <= '0;
            done_reg         <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        vd_index_reg <= vd_index;
                        count_reg    <= chunk_count;
                        bit_mode_reg <= bit_mode;
                        mask_reg     <= mask_mode;
                        widen_reg    <= widening_mode & ~mask_mode;
                        k_reg        <= '0;
                        mask_acc_reg <= '0;
                        state_reg    <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (count_reg == 4'd0) begin
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                    end else if (result_valid) begin
                        k_reg            <= k_reg + 4'd1;
                        vd_high_hold_reg <= result_vd_high;
                        if (mask_reg) begin
                            mask_acc_reg <= mask_next;
                            if (last_accept) begin
                                write_valid_reg <= 1'b1;
                                write_index_reg <= vd_index_reg;
                                write_chunk_reg <= '0;
                                write_data_reg  <= mask_next;
                                state_reg       <= WRITE_MASK;
                            end
                        end else begin
                            write_valid_reg <= 1'b1;
                            write_index_reg <= lin_low[LW-1:CHUNK_INDEX_WIDTH];
                            write_chunk_reg <= lin_low[CHUNK_INDEX_WIDTH-1:0];
                            write_data_reg  <= result_vd;
                            state_reg       <= WRITE_LOW;
                        end
                    end
                end
                WRITE_LOW: begin
                    if (write_ready) begin
                        if (widen_reg) begin
                            write_index_reg <= lin_high[LW-1:CHUNK_INDEX_WIDTH];
                            write_chunk_reg <= lin_high[CHUNK_INDEX_WIDTH-1:0];
                            write_data_reg  <= vd_high_hold_reg;
                            state_reg       <= WRITE_HIGH;
                        end else begin
                            write_valid_reg <= 1'b0;
                            done_reg        <= all_written;
                            state_reg       <= all_written ? DONE : COLLECT;
                        end
                    end
                end
                WRITE_HIGH: begin
                    if (write_ready) begin
                        write_valid_reg <= 1'b0;
                        done_reg        <= all_written;
                        state_reg       <= all_written ? DONE : COLLECT;
                    end
                end
                WRITE_MASK: begin
                    if (write_ready) begin
                        write_valid_reg <= 1'b0;
                        done_reg        <= 1'b1;
                        state_reg       <= DONE;
                    end
                end
                DONE:    state_reg <= IDLE;
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule
